// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command sequencer for the 8-bit shifter datapath
//
// Accepts one command (load value, direction, total shift amount), loads the
// shifter register, then walks it in steps of at most 3 bits per cycle until
// the total is reached. The final register value is captured into result and
// announced with a one-cycle done pulse.
//
// Ports:
//   clk       in   1      clock, rising edge
//   reset_n   in   1      asynchronous reset, active low
//   start     in   1      command strobe, sampled only in IDLE
//   abort     in   1      cancel the command in flight (LOAD/SHIFT only)
//   cmd_op    in   2      00 load-only, 01 LSL, 10 LSR, 11 ASR
//   cmd_amt   in   AMT_W  total shift amount
//   cmd_data  in   8      value to load
//   sh_op     out  3      000 NOP(clear), 001 LOAD, 010 LSL, 011 LSR, 100 ASR
//   sh_shamt  out  2      per-step shift amount
//   sh_d_in   out  8      shifter load data
//   sh_d_out  in   8      current shifter register value
//   busy      out  1      high whenever not IDLE
//   done      out  1      one-cycle pulse in the DONE state
//   result    out  8      final value, held until the next done

module shift_seq_ctrl #(
  parameter int AMT_W = 5,
  parameter bit CLAMP = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [7:0]       cmd_data,
  output logic [2:0]       sh_op,
  output logic [1:0]       sh_shamt,
  output logic [7:0]       sh_d_in,
  input  logic [7:0]       sh_d_out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [1:0]       op_q;
  logic [7:0]       data_q;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] eff_amt;
  logic [AMT_W-1:0] rem_after;
  logic [1:0]       step;
  logic [2:0]       op_moore;
  logic             accept;

  // Any shift of 8 or more leaves the same value as a shift of exactly 8,
  // so clamping only shortens the sequence.
  always_comb begin
    eff_amt = cmd_amt;
    if (CLAMP && (int'(cmd_amt) > 8)) begin
      eff_amt = AMT_W'(8);
    end
  end

  // Step never exceeds rem, so rem cannot wrap below zero.
  assign step      = (rem >= AMT_W'(3)) ? 2'd3 : rem[1:0];
  assign rem_after = rem - AMT_W'(step);
  assign accept    = (state == S_IDLE) && start && !abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      rem    <= '0;
      op_q   <= 2'b00;
      data_q <= 8'h00;
      result <= 8'h00;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        rem    <= eff_amt;
      end
      if (state == S_SHIFT) begin
        rem <= rem_after;
      end
      // The last shift lands on the edge entering DONE, so sh_d_out is final here.
      if (state == S_DONE) begin
        result <= sh_d_out;
      end
    end
  end

  always_comb begin
    state_nx = state;
    op_moore = OP_LSL;
    sh_shamt = 2'd0;
    sh_d_in  = 8'h00;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        op_moore = OP_LOAD;
        sh_d_in  = data_q;
        if (abort) begin
          state_nx = S_IDLE;
        end else if ((rem == '0) || (op_q == 2'b00)) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        unique case (op_q)
          2'b01:   op_moore = OP_LSL;
          2'b10:   op_moore = OP_LSR;
          default: op_moore = OP_ASR;
        endcase
        sh_shamt = step;
        if (abort) begin
          state_nx = S_IDLE;
        end else if (rem_after == '0) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // NOP clears the shifter, so it is shown only while reset is actually held.
  assign sh_op = reset_n ? op_moore : OP_NOP;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - randomized self-checking bench for shift_seq_ctrl

module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [4:0] cmd_amt = 5'd0;
  logic [7:0] cmd_data = 8'h00;

  logic [2:0] op_a, op_b;
  logic [1:0] sa_a, sa_b;
  logic [7:0] din_a, din_b, dout_a, dout_b, res_a, res_b;
  logic       busy_a, busy_b, done_a, done_b;

  int n_checks = 0;
  int n_fail = 0;
  int exp_res_a = 0;
  int exp_res_b = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.AMT_W(5), .CLAMP(1'b1)) dut_a (
    .clk(clk), .reset_n(rst_n), .start(start), .abort(abort),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .sh_op(op_a), .sh_shamt(sa_a), .sh_d_in(din_a), .sh_d_out(dout_a),
    .busy(busy_a), .done(done_a), .result(res_a)
  );

  shift_seq_ctrl #(.AMT_W(5), .CLAMP(1'b0)) dut_b (
    .clk(clk), .reset_n(rst_n), .start(start), .abort(abort),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .sh_op(op_b), .sh_shamt(sa_b), .sh_d_in(din_b), .sh_d_out(dout_b),
    .busy(busy_b), .done(done_b), .result(res_b)
  );

  function automatic logic [7:0] shifter(logic [7:0] r, logic [2:0] op,
                                         logic [1:0] sa, logic [7:0] d);
    case (op)
      3'd0:    return 8'h00;
      3'd1:    return d;
      3'd2:    return r << sa;
      3'd3:    return r >> sa;
      3'd4:    return 8'($signed(r) >>> sa);
      default: return r;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_a <= 8'h00;
    else        dout_a <= shifter(dout_a, op_a, sa_a, din_a);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_b <= 8'h00;
    else        dout_b <= shifter(dout_b, op_b, sa_b, din_b);
  end

  task automatic check(string tag, int obs, int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff_amount(int amt, bit clamp);
    return (clamp && amt > 8) ? 8 : amt;
  endfunction

  function automatic int n_shifts(int op, int eff);
    return (op == 0) ? 0 : (eff + 2) / 3;
  endfunction

  function automatic int ref_result(int op, int data, int amt);
    int s;
    case (op)
      0:       return data;
      1:       return (data << amt) & 255;
      2:       return data >> amt;
      default: begin
        s = (data >= 128) ? data - 256 : data;
        return (s >>> amt) & 255;
      end
    endcase
  endfunction

  // c counts cycles after the edge that sampled start: 1 is LOAD.
  task automatic check_cyc(string who, int c, int n, bit killed, int op, int data,
                           int eff, logic [2:0] so, logic [1:0] ss,
                           logic [7:0] di, logic b, logic d);
    int rem;
    if (killed || c > n + 2) begin
      check({who, "_idle_busy"}, b, 0);
      check({who, "_idle_done"}, d, 0);
      check({who, "_idle_op"}, so, 2);
      check({who, "_idle_shamt"}, ss, 0);
    end else if (c == 1) begin
      check({who, "_load_busy"}, b, 1);
      check({who, "_load_op"}, so, 1);
      check({who, "_load_din"}, di, data);
      check({who, "_load_done"}, d, 0);
    end else if (c <= n + 1) begin
      rem = eff - 3 * (c - 2);
      check({who, "_shift_busy"}, b, 1);
      check({who, "_shift_op"}, so, op + 1);
      check({who, "_shift_shamt"}, ss, (rem > 3) ? 3 : rem);
      check({who, "_shift_done"}, d, 0);
    end else begin
      check({who, "_done_busy"}, b, 1);
      check({who, "_done_pulse"}, d, 1);
      check({who, "_done_op"}, so, 2);
      check({who, "_done_shamt"}, ss, 0);
    end
  endtask

  // abort_c / start_c: cycle (1 = LOAD) in which abort / a stray start is held; 0 = never.
  task automatic run_cmd(int op, int amt, int data, int abort_c, int start_c);
    int ea, eb, na, nb, last, da, db;
    bit ka, kb;
    ea = eff_amount(amt, 1'b1);
    eb = eff_amount(amt, 1'b0);
    na = n_shifts(op, ea);
    nb = n_shifts(op, eb);
    ka = (abort_c > 0) && (abort_c <= na + 1);
    kb = (abort_c > 0) && (abort_c <= nb + 1);
    last = ((na > nb) ? na : nb) + 3;
    da = 0;
    db = 0;
    @(negedge clk);
    start = 1'b1;
    cmd_op = 2'(op);
    cmd_amt = 5'(amt);
    cmd_data = 8'(data);
    @(posedge clk);
    #1;
    start = 1'b0;
    cmd_data = ~8'(data);
    cmd_op = 2'($urandom_range(0, 3));
    for (int c = 1; c <= last; c++) begin
      abort = (c == abort_c);
      start = (c == start_c);
      @(negedge clk);
      check_cyc("a", c, na, ka && c > abort_c, op, data, ea, op_a, sa_a, din_a, busy_a, done_a);
      check_cyc("b", c, nb, kb && c > abort_c, op, data, eb, op_b, sa_b, din_b, busy_b, done_b);
      da += int'(done_a);
      db += int'(done_b);
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
    start = 1'b0;
    if (!ka) exp_res_a = ref_result(op, data, ea);
    if (!kb) exp_res_b = ref_result(op, data, eb);
    check("a_done_count", da, ka ? 0 : 1);
    check("b_done_count", db, kb ? 0 : 1);
    check("a_result", res_a, exp_res_a);
    check("b_result", res_b, exp_res_b);
  endtask

  initial begin
    int op, amt, na, ac, sc;
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_result", res_a, 0);
    check("rst_op", op_a, 0);
    check("rst_shamt", sa_a, 0);
    check("rst_din", din_a, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_hold_op", op_a, 2);
    check("post_rst_hold_shamt", sa_a, 0);
    check("post_rst_busy", busy_b, 0);

    run_cmd(1, 5, 8'h81, 0, 0);
    check("t1_value", res_a, 8'h20);
    run_cmd(3, 7, 8'h90, 0, 0);
    check("t2_value", res_a, 8'hFF);
    run_cmd(0, 9, 8'h5A, 0, 0);
    run_cmd(1, 0, 8'h5A, 0, 0);
    check("t3_value", res_a, 8'h5A);
    run_cmd(1, 5, 8'h81, 3, 2);
    check("t5_result_kept", res_a, 8'h5A);
    run_cmd(2, 31, 8'hF0, 0, 0);
    check("t4_value_a", res_a, 8'h00);
    check("t4_value_b", res_b, 8'h00);

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    cmd_op = 2'b01;
    cmd_amt = 5'd3;
    cmd_data = 8'h11;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_start_busy_a", busy_a, 0);
      check("abort_start_busy_b", busy_b, 0);
      check("abort_start_done", done_a, 0);
    end

    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 3);
      amt = $urandom_range(0, 31);
      na = n_shifts(op, eff_amount(amt, 1'b1));
      ac = ($urandom_range(0, 3) == 0) ? $urandom_range(1, na + 2) : 0;
      sc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (ac > 0) ? ac : na + 2) : 0;
      run_cmd(op, amt, $urandom_range(0, 255), ac, sc);
    end

    run_cmd(3, 7, 8'h90, 0, 0);
    check("pre_rst_result", res_a, 8'hFF);
    // reset dropped mid-SHIFT
    @(negedge clk);
    start = 1'b1;
    cmd_op = 2'b01;
    cmd_amt = 5'd9;
    cmd_data = 8'hC3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("mid_pre_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy_a", busy_a, 0);
    check("mid_rst_busy_b", busy_b, 0);
    check("mid_rst_done", done_a, 0);
    check("mid_rst_result_a", res_a, 0);
    check("mid_rst_result_b", res_b, 0);
    check("mid_rst_op_a", op_a, 0);
    check("mid_rst_op_b", op_b, 0);
    exp_res_a = 0;
    exp_res_b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_hold_op", op_a, 2);
    check("mid_rel_hold_shamt", sa_a, 0);
    run_cmd(2, 4, 8'hB6, 0, 0);
    check("after_rst_value", res_a, 8'h0B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
